// File: rtl/ropuf_challenge_sequencer.sv
// Challenge sequencer for the RO PUF key generator: expands one seed challenge into
// NUM_PAIRS distinct ring-oscillator index pairs offered over a valid/ready handshake.
module ropuf_challenge_sequencer #(
    parameter int unsigned     CH_W      = 16,
    parameter int unsigned     IDX_W     = 4,
    parameter int unsigned     ROT_STEP  = 1,
    parameter int unsigned     NUM_PAIRS = 128,
    parameter logic [CH_W-1:0] LFSR_TAPS = 16'h002D,
    localparam int unsigned    CNT_W     = $clog2(NUM_PAIRS + 1)
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [CH_W-1:0]  challenge,
    input  logic             mode,
    input  logic             abort,
    input  logic             pair_ready,
    output logic             pair_valid,
    output logic [IDX_W-1:0] idx_a,
    output logic [IDX_W-1:0] idx_b,
    output logic [CNT_W-1:0] pair_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       fsm;
    logic [CH_W-1:0]  state;
    logic [CH_W-1:0]  state_next;
    logic             mode_q;
    logic [IDX_W-1:0] raw_b;
    logic             last_pair;

    // Both indices come straight from the registered state so they stay stable under backpressure.
    assign idx_a = state[CH_W-1 -: IDX_W];
    assign raw_b = state[CH_W-IDX_W-1 -: IDX_W];
    assign idx_b = (raw_b != idx_a) ? raw_b : idx_a + 1'b1;

    assign pair_valid = (fsm == ST_GEN);
    assign busy       = (fsm != ST_IDLE);
    assign done       = (fsm == ST_DONE);
    assign last_pair  = (pair_cnt == CNT_W'(NUM_PAIRS - 1));

    // NOTE: the rotate result is assigned first as a default, so every path writes state_next and no latch is inferred.
    always_comb begin
        state_next = {state[ROT_STEP-1:0], state[CH_W-1:ROT_STEP]};
        if (mode_q) begin
            state_next = {^(state & LFSR_TAPS), state[CH_W-1:1]};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsm      <= ST_IDLE;
            state    <= '0;
            mode_q   <= 1'b0;
            pair_cnt <= '0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (start && !abort) begin
                        // An all-zero seed would lock the LFSR at zero forever.
                        state    <= (mode && (challenge == '0)) ? CH_W'(1) : challenge;
                        mode_q   <= mode;
                        pair_cnt <= '0;
                        fsm      <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    if (abort) begin
                        fsm <= ST_IDLE;
                    end else if (pair_ready) begin
                        state    <= state_next;
                        pair_cnt <= pair_cnt + 1'b1;
                        if (last_pair) begin
                            fsm <= ST_DONE;
                        end
                    end
                end
                ST_DONE: fsm <= ST_IDLE;
                default: fsm <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ropuf_challenge_sequencer.md
Name: ropuf_challenge_sequencer

Overview:
Parametrised challenge sequencer for the RO PUF key generator. It expands one seed challenge into NUM_PAIRS ring-oscillator index pairs (idx_a, idx_b). Each pair is offered to the RO counter/comparator stage over a valid/ready handshake. It generalises the fixed 16-bit rotate-and-select sequencer:
- configurable width and pair count
- rotate or LFSR stepping
- backpressure, abort, completion signalling

Parameters:
CH_W, 16, challenge/state width in bits; must satisfy CH_W >= 2*IDX_W
IDX_W, 4, width of each RO index (selects one of 2^IDX_W oscillators)
ROT_STEP, 1, rotate-right distance per step in mode 0; range 1..CH_W-1
NUM_PAIRS, 128, pairs generated per start
LFSR_TAPS, 16'h002D, feedback mask for mode 1, CH_W bits wide

Ports:
clk  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a sequence; honoured only in IDLE
challenge  in  CH_W  seed; sampled on the start edge
mode  in  1  0 = rotate right by ROT_STEP, 1 = Fibonacci LFSR; sampled on the start edge
abort  in  1  synchronous return to IDLE
pair_ready  in  1  consumer accepts the current pair
pair_valid  out  1  idx_a/idx_b hold a valid pair
idx_a  out  IDX_W  first RO index
idx_b  out  IDX_W  second RO index; never equals idx_a while pair_valid=1
pair_cnt  out  $clog2(NUM_PAIRS+1)  handshakes completed in the current sequence
busy  out  1  high whenever FSM != IDLE
done  out  1  one-cycle pulse at sequence end

Behaviour:
- Reset (Reset_n=0, asynchronous, any time including mid-sequence): FSM=IDLE, state=0, mode_q=0, pair_cnt=0. Outputs: pair_valid=0, busy=0, done=0, idx_a=0, idx_b=1.
- FSM states: IDLE, GEN, DONE.
- IDLE:
  - On start=1: state <= challenge, mode_q <= mode, pair_cnt <= 0, go to GEN.
  - If mode=1 and challenge=0, load state=1 instead (avoids LFSR lock-up).
  - start in any other state is ignored.
- Pair extraction (combinational from the registered state):
  - idx_a = state[CH_W-1 -: IDX_W]
  - raw_b = state[CH_W-IDX_W-1 -: IDX_W]
  - idx_b = raw_b if raw_b != idx_a, else idx_a+1 mod 2^IDX_W (wraps, e.g. F -> 0)
- GEN:
  - pair_valid=1. The first pair is visible the cycle after the start edge (latency 1).
  - Handshake fires when pair_valid and pair_ready are both 1 on a rising edge. Then pair_cnt increments and the state advances.
  - With pair_ready=0, state, idx_a, idx_b and pair_cnt hold stable.
- State advance:
  - Mode 0: state <= {state[ROT_STEP-1:0], state[CH_W-1:ROT_STEP]}.
  - Mode 1: fb = ^(state & LFSR_TAPS); state <= {fb, state[CH_W-1:1]}.
- Termination: a handshake with pair_cnt == NUM_PAIRS-1 moves the FSM to DONE (pair_cnt reaches NUM_PAIRS).
- DONE: pair_valid=0, done=1 for exactly one cycle, then IDLE. pair_cnt holds its final value until the next start.
- abort=1 in GEN or DONE: next state IDLE, pair_valid=0 the next cycle, done not pulsed, pair_cnt holds. abort has priority over a simultaneous handshake, so no increment occurs.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins, stay IDLE.
- mode and challenge changes after the start edge have no effect.

Test Plan:
- CH_W=16, IDX_W=4, mode 0, challenge 16'h3A5C, pair_ready=1 -> pair 1 = (3,A). After one handshake, state=16'h1D2E, pair 2 = (1,D). pair_cnt=1 after the first edge.
- Equality fix-up: challenge 16'h7712 -> (7,8). challenge 16'hFF00 -> (F,0) via wrap. idx_a != idx_b on every valid cycle of a random 1000-pair run.
- Backpressure: pair_ready low for 3 cycles mid-sequence -> idx_a, idx_b and pair_cnt stable. Exactly one increment when ready returns.
- NUM_PAIRS=4 with ready always high -> valid for 4 cycles, done pulses 1 cycle on the cycle after the 4th handshake, pair_cnt=4, busy falls with return to IDLE.
- LFSR lock-up guard: mode 1, challenge 0 -> state 16'h0001 gives pair (0,1). Next state 16'h8000 gives pair (8,0).
- Reset_n pulsed low mid-GEN, asynchronously between edges -> pair_valid=0 and busy=0 immediately. abort mid-GEN -> IDLE, no done pulse. A new start then restarts from pair_cnt=0.
